// File: rtl/in_service_controller.sv
// In-service register and INTA acknowledge sequencer for an 8259-style interrupt controller.
// Tracks ISR bits, drives the two-pulse INTA handshake, handles EOI/AEOI and priority rotation.
module in_service_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       inta_pulse,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       auto_rotate,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  input  logic       set_priority_strobe,
  input  logic [2:0] set_priority_level,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_irr,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [0:0] {IDLE, WAIT_ACK2} state_t;

  state_t     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic       int_out_q, int_out_d;
  logic [7:0] clear_irr_q, clear_irr_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;

  logic [7:0] isr_set, isr_clr;
  logic [2:0] req_level;
  logic       aeoi_rot_en, eoi_rot_en;
  logic [2:0] aeoi_rot_lvl, eoi_rot_lvl;
  logic       ns_found;
  logic [2:0] ns_level, scan_idx;

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    spurious_d     = spurious_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    clear_irr_d    = '0;
    rot_d          = rot_q;
    isr_set        = '0;
    isr_clr        = '0;
    req_level      = '0;
    aeoi_rot_en    = 1'b0;
    aeoi_rot_lvl   = '0;
    eoi_rot_en     = 1'b0;
    eoi_rot_lvl    = '0;
    ns_found       = 1'b0;
    ns_level       = '0;
    scan_idx       = '0;

    // Lowest set index wins if the resolver ever hands over more than one bit.
    for (int unsigned i = 0; i < 8; i++) begin
      if (interrupt[3'(7 - i)]) req_level = 3'(7 - i);
    end

    unique case (state_q)
      IDLE: begin
        if (inta_pulse) begin
          state_d = WAIT_ACK2;
          if (interrupt != '0) begin
            level_d            = req_level;
            spurious_d         = 1'b0;
            isr_set[req_level] = 1'b1;
            clear_irr_d        = isr_set;
          end else begin
            level_d    = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      WAIT_ACK2: begin
        if (inta_pulse) begin
          state_d        = IDLE;
          vector_d       = {vector_base, level_q};
          vector_valid_d = 1'b1;
          if (auto_eoi && !spurious_q) begin
            isr_clr[level_q] = 1'b1;
            aeoi_rot_en      = auto_rotate;
            aeoi_rot_lvl     = level_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Non-specific EOI: first set ISR bit starting at the current highest-priority level.
    for (int unsigned k = 0; k < 8; k++) begin
      scan_idx = rot_q + 3'(k);
      if (!ns_found && isr_q[scan_idx]) begin
        ns_found = 1'b1;
        ns_level = scan_idx;
      end
    end

    if (eoi_strobe) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
        eoi_rot_en         = eoi_rotate;
        eoi_rot_lvl        = eoi_level + 3'd1;
      end else if (ns_found) begin
        isr_clr[ns_level] = 1'b1;
        eoi_rot_en        = eoi_rotate;
        eoi_rot_lvl       = ns_level + 3'd1;
      end
    end

    if (set_priority_strobe) begin
      rot_d = set_priority_level + 3'd1;
    end else if (eoi_rot_en) begin
      rot_d = eoi_rot_lvl;
    end else if (aeoi_rot_en) begin
      rot_d = aeoi_rot_lvl;
    end

    isr_d     = (isr_q & ~isr_clr) | isr_set;
    int_out_d = (state_d == IDLE) && (interrupt != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      level_q        <= '0;
      spurious_q     <= 1'b0;
      isr_q          <= '0;
      rot_q          <= '0;
      int_out_q      <= 1'b0;
      clear_irr_q    <= '0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      spurious_q     <= spurious_d;
      isr_q          <= isr_d;
      rot_q          <= rot_d;
      int_out_q      <= int_out_d;
      clear_irr_q    <= clear_irr_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign int_out             = int_out_q;
  assign in_service_register = isr_q;
  assign priority_rotate     = rot_q;
  assign clear_irr           = clear_irr_q;
  assign vector_out          = vector_q;
  assign vector_valid        = vector_valid_q;

endmodule

// File: tb/tb_in_service_controller.sv
// Bench for in_service_controller: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the acknowledge/EOI rules.
module tb_in_service_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       inta_pulse;
  logic [4:0] vector_base;
  logic       auto_eoi, auto_rotate;
  logic       eoi_strobe, eoi_specific, eoi_rotate;
  logic [2:0] eoi_level;
  logic       set_priority_strobe;
  logic [2:0] set_priority_level;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_irr;
  logic [7:0] vector_out;
  logic       vector_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit         m_wait;
  bit         m_spur;
  int         m_level;
  logic [7:0] m_isr;
  int         m_rot;
  bit         m_int;
  logic [7:0] m_clr;
  logic [7:0] m_vec;
  bit         m_vv;

  always #5 clock = ~clock;

  in_service_controller dut (
    .clock               (clock),
    .reset               (reset),
    .interrupt           (interrupt),
    .inta_pulse          (inta_pulse),
    .vector_base         (vector_base),
    .auto_eoi            (auto_eoi),
    .auto_rotate         (auto_rotate),
    .eoi_strobe          (eoi_strobe),
    .eoi_specific        (eoi_specific),
    .eoi_rotate          (eoi_rotate),
    .eoi_level           (eoi_level),
    .set_priority_strobe (set_priority_strobe),
    .set_priority_level  (set_priority_level),
    .int_out             (int_out),
    .in_service_register (in_service_register),
    .priority_rotate     (priority_rotate),
    .clear_irr           (clear_irr),
    .vector_out          (vector_out),
    .vector_valid        (vector_valid)
  );

  // Advance one clock: predict from current inputs, clock the DUT, settle,
  // then drop the one-cycle strobes.
  task automatic tick();
    bit         n_wait, n_spur, n_vv, n_int, found;
    int         n_level, n_rot, eoi_rot, aeoi_rot, j;
    logic [7:0] n_isr, n_clr, n_vec, set_b, clr_b;
    n_wait = m_wait; n_spur = m_spur; n_level = m_level; n_rot = m_rot;
    n_vec = m_vec; n_vv = 0; n_clr = 8'h00; set_b = 8'h00; clr_b = 8'h00;
    eoi_rot = -1; aeoi_rot = -1; found = 0; n_isr = m_isr; n_int = 0;
    if (reset) begin
      n_wait = 0; n_spur = 0; n_level = 0; n_isr = 8'h00; n_rot = 0; n_vec = 8'h00;
    end else begin
      if (!m_wait && inta_pulse) begin
        n_wait = 1;
        if (interrupt == 8'h00) begin
          n_level = 7; n_spur = 1;
        end else begin
          for (int i = 7; i >= 0; i--) if (interrupt[i]) n_level = i;
          n_spur = 0; set_b[n_level] = 1'b1; n_clr = set_b;
        end
      end else if (m_wait && inta_pulse) begin
        n_wait = 0; n_vv = 1;
        n_vec = 8'(int'(vector_base) * 8 + m_level);
        if (auto_eoi && !m_spur) begin
          clr_b[m_level] = 1'b1;
          if (auto_rotate) aeoi_rot = (m_level + 1) % 8;
        end
      end
      if (eoi_strobe) begin
        if (eoi_specific) begin
          clr_b[eoi_level] = 1'b1;
          if (eoi_rotate) eoi_rot = (int'(eoi_level) + 1) % 8;
        end else begin
          for (int k = 0; k < 8; k++) begin
            j = (m_rot + k) % 8;
            if (!found && m_isr[j]) begin
              found = 1; clr_b[j] = 1'b1;
              if (eoi_rotate) eoi_rot = (j + 1) % 8;
            end
          end
        end
      end
      if (set_priority_strobe)  n_rot = (int'(set_priority_level) + 1) % 8;
      else if (eoi_rot >= 0)    n_rot = eoi_rot;
      else if (aeoi_rot >= 0)   n_rot = aeoi_rot;
      for (int b = 0; b < 8; b++) n_isr[b] = set_b[b] | (m_isr[b] & ~clr_b[b]);
      n_int = !n_wait && (interrupt != 8'h00);
    end
    @(posedge clock);
    m_wait = n_wait; m_spur = n_spur; m_level = n_level; m_isr = n_isr; m_rot = n_rot;
    m_int = n_int; m_clr = n_clr; m_vec = n_vec; m_vv = n_vv;
    #1;
    inta_pulse = 0; eoi_strobe = 0; set_priority_strobe = 0;
  endtask

  // Two-pulse acknowledge of one request, stimulus only.
  task automatic ack(input logic [7:0] irq);
    interrupt = irq; inta_pulse = 1; tick();
    interrupt = 8'h00; inta_pulse = 1; tick();
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out got=%b want=0", int_out); end
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL reset_isr got=%h want=00", in_service_register); end
    checks++; if (priority_rotate !== 3'd0) begin errors++; $display("FAIL reset_rot got=%0d want=0", priority_rotate); end
    checks++; if (clear_irr !== 8'h00) begin errors++; $display("FAIL reset_clear_irr got=%h want=00", clear_irr); end
    checks++; if (vector_out !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h want=00", vector_out); end
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vvalid got=%b want=0", vector_valid); end
  endtask

  task automatic test_basic_ack();
    interrupt = 8'h08; vector_base = 5'b01000; tick();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int_req got=%b want=1", int_out); end
    inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h08) begin errors++; $display("FAIL basic_isr got=%h want=08", in_service_register); end
    checks++; if (clear_irr !== 8'h08) begin errors++; $display("FAIL basic_clear_irr got=%h want=08", clear_irr); end
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_wait got=%b want=0", int_out); end
    tick();
    checks++; if (clear_irr !== 8'h00) begin errors++; $display("FAIL basic_clear_once got=%h want=00", clear_irr); end
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_wait2 got=%b want=0", int_out); end
    interrupt = 8'h00; inta_pulse = 1; tick();
    checks++; if (vector_out !== 8'h43) begin errors++; $display("FAIL basic_vector got=%h want=43", vector_out); end
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL basic_vvalid got=%b want=1", vector_valid); end
    tick();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL basic_vvalid_pulse got=%b want=0", vector_valid); end
    checks++; if (vector_out !== 8'h43) begin errors++; $display("FAIL basic_vector_hold got=%h want=43", vector_out); end
    eoi_strobe = 1; eoi_specific = 0; eoi_rotate = 0; tick();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL basic_ns_eoi got=%h want=00", in_service_register); end
  endtask

  task automatic test_spurious();
    interrupt = 8'h00; vector_base = 5'b00010; inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL spur_isr got=%h want=00", in_service_register); end
    checks++; if (clear_irr !== 8'h00) begin errors++; $display("FAIL spur_clear_irr got=%h want=00", clear_irr); end
    inta_pulse = 1; tick();
    checks++; if (vector_out !== 8'h17) begin errors++; $display("FAIL spur_vector got=%h want=17", vector_out); end
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL spur_vvalid got=%b want=1", vector_valid); end
  endtask

  task automatic test_eoi_rotate();
    ack(8'h04); ack(8'h20);
    set_priority_strobe = 1; set_priority_level = 3'd2; tick();
    checks++; if (in_service_register !== 8'h24) begin errors++; $display("FAIL rot_isr_setup got=%h want=24", in_service_register); end
    checks++; if (priority_rotate !== 3'd3) begin errors++; $display("FAIL rot_setpri got=%0d want=3", priority_rotate); end
    eoi_strobe = 1; eoi_specific = 0; eoi_rotate = 1; tick();
    checks++; if (in_service_register !== 8'h04) begin errors++; $display("FAIL rot_ns_isr got=%h want=04", in_service_register); end
    checks++; if (priority_rotate !== 3'd6) begin errors++; $display("FAIL rot_ns_rot got=%0d want=6", priority_rotate); end
    eoi_strobe = 1; eoi_specific = 1; eoi_rotate = 0; eoi_level = 3'd2; tick();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL rot_spec_isr got=%h want=00", in_service_register); end
    checks++; if (priority_rotate !== 3'd6) begin errors++; $display("FAIL rot_spec_keep got=%0d want=6", priority_rotate); end
  endtask

  task automatic test_aeoi_wrap();
    auto_eoi = 1; auto_rotate = 1;
    interrupt = 8'h80; inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h80) begin errors++; $display("FAIL aeoi_set got=%h want=80", in_service_register); end
    interrupt = 8'h00; inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL aeoi_clear got=%h want=00", in_service_register); end
    checks++; if (priority_rotate !== 3'd0) begin errors++; $display("FAIL aeoi_wrap got=%0d want=0", priority_rotate); end
    auto_eoi = 0; auto_rotate = 0;
  endtask

  task automatic test_set_wins();
    ack(8'h02);
    interrupt = 8'h02; inta_pulse = 1;
    eoi_strobe = 1; eoi_specific = 1; eoi_rotate = 0; eoi_level = 3'd1; tick();
    checks++; if (in_service_register !== 8'h02) begin errors++; $display("FAIL setwins_isr got=%h want=02", in_service_register); end
    checks++; if (clear_irr !== 8'h02) begin errors++; $display("FAIL setwins_clear_irr got=%h want=02", clear_irr); end
    interrupt = 8'h00; inta_pulse = 1; tick();
    eoi_strobe = 1; eoi_specific = 1; eoi_level = 3'd1; tick();
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL setwins_cleanup got=%h want=00", in_service_register); end
  endtask

  task automatic test_reset_in_wait();
    vector_base = 5'b10101;
    interrupt = 8'h10; inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h10) begin errors++; $display("FAIL rstwait_setup got=%h want=10", in_service_register); end
    reset = 1; inta_pulse = 1; tick(); reset = 0;
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL rstwait_isr got=%h want=00", in_service_register); end
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL rstwait_vvalid got=%b want=0", vector_valid); end
    interrupt = 8'h01; inta_pulse = 1; tick();
    checks++; if (in_service_register !== 8'h01) begin errors++; $display("FAIL rstwait_first_isr got=%h want=01", in_service_register); end
    checks++; if (clear_irr !== 8'h01) begin errors++; $display("FAIL rstwait_first_clr got=%h want=01", clear_irr); end
    interrupt = 8'h00; inta_pulse = 1; tick();
    checks++; if (vector_out !== 8'hA8) begin errors++; $display("FAIL rstwait_vector got=%h want=a8", vector_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset               = ($urandom_range(0, 99) == 0);
      interrupt           = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      inta_pulse          = ($urandom_range(0, 2) == 0);
      vector_base         = 5'($urandom);
      auto_eoi            = 1'($urandom);
      auto_rotate         = 1'($urandom);
      eoi_strobe          = ($urandom_range(0, 4) == 0);
      eoi_specific        = 1'($urandom);
      eoi_rotate          = 1'($urandom);
      eoi_level           = 3'($urandom);
      set_priority_strobe = ($urandom_range(0, 9) == 0);
      set_priority_level  = 3'($urandom);
      tick();
      checks++; if (in_service_register !== m_isr) begin errors++; $display("FAIL rnd_isr cyc=%0d got=%h want=%h", n, in_service_register, m_isr); end
      checks++; if (int'(priority_rotate) !== m_rot) begin errors++; $display("FAIL rnd_rot cyc=%0d got=%0d want=%0d", n, priority_rotate, m_rot); end
      checks++; if (clear_irr !== m_clr) begin errors++; $display("FAIL rnd_clear_irr cyc=%0d got=%h want=%h", n, clear_irr, m_clr); end
      checks++; if (int_out !== m_int) begin errors++; $display("FAIL rnd_int_out cyc=%0d got=%b want=%b", n, int_out, m_int); end
      checks++; if (vector_out !== m_vec) begin errors++; $display("FAIL rnd_vector cyc=%0d got=%h want=%h", n, vector_out, m_vec); end
      checks++; if (vector_valid !== m_vv) begin errors++; $display("FAIL rnd_vvalid cyc=%0d got=%b want=%b", n, vector_valid, m_vv); end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; interrupt = 8'h00; inta_pulse = 0; vector_base = 5'd0;
    auto_eoi = 0; auto_rotate = 0; eoi_strobe = 0; eoi_specific = 0; eoi_rotate = 0;
    eoi_level = 3'd0; set_priority_strobe = 0; set_priority_level = 3'd0;
    m_wait = 0; m_spur = 0; m_level = 0; m_isr = 8'h00; m_rot = 0;
    m_int = 0; m_clr = 8'h00; m_vec = 8'h00; m_vv = 0;
    @(posedge clock); #1;
    test_reset();
    test_basic_ack();
    test_spurious();
    test_eoi_rotate();
    test_aeoi_wrap();
    test_set_wins();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
